// File: rtl/nes_romloader_pkg.sv
// Shared types and constants for the iNES ROM loader: FSM states, header layout,
// section unit sizes and trainer length.
package nes_romload_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_TRAINER,
    S_PRG,
    S_CHR,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [31:0] INES_MAGIC  = 32'h4E45_531A;
  localparam int          HDR_PRG     = 4;
  localparam int          HDR_CHR     = 5;
  localparam int          HDR_FLAGS6  = 6;
  localparam int          HDR_FLAGS7  = 7;
  localparam int          HDR_LAST    = 15;
  localparam int          PRG_UNIT    = 16384;
  localparam int          CHR_UNIT    = 8192;
  localparam int          TRAINER_LEN = 512;

  // Magic byte expected at header position idx (0..3), first byte in the MSBs.
  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    return 8'(INES_MAGIC >> (8 * (3 - int'(idx))));
  endfunction

endpackage

// File: rtl/nes_romloader_if.sv
// Byte-wide SDRAM write port: level request held until a one-cycle acknowledge.
interface nes_romloader_if;
  logic        mem_req;
  logic [22:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;

  modport master (output mem_req, output mem_addr, output mem_wdata, input mem_ack);
  modport slave  (input mem_req, input mem_addr, input mem_wdata, output mem_ack);
endinterface

// File: rtl/romload_fifo.sv
// Synchronous write buffer between the byte parser and the SDRAM port.
// Push is refused when full, pop when empty; flush empties it in one cycle.
module romload_fifo #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = mem_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/nes_romloader.sv
// iNES stream parser: validates the header, publishes cartridge config and writes PRG/CHR
// bytes to SDRAM through a FIFO. NES_ROMLOAD_TRAINER_EN enables skipping the 512-byte trainer.
module nes_romloader
  import nes_romload_pkg::*;
#(
  parameter logic [22:0] PRG_BASE   = 23'h000000,
  parameter logic [22:0] CHR_BASE   = 23'h400000,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rom_loading,
  input  logic [7:0]             rom_do,
  input  logic                   rom_do_valid,
  nes_romloader_if.master        mem,
  output logic                   loaded,
  output logic                   error,
  output logic [7:0]             prg_units,
  output logic [7:0]             chr_units,
  output logic [7:0]             mapper,
  output logic                   mirroring,
  output logic                   battery
);

  state_t      state, state_n;
  logic [21:0] cnt, cnt_n;
  logic        loading_q;
  logic        valid_q;
  logic        load_start;
  logic        load_end;
  logic        byte_stb;
  logic        hdr_we;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic [30:0] push_data;
  logic [30:0] head;
  logic [21:0] prg_len;
  logic [21:0] chr_len;
`ifdef NES_ROMLOAD_TRAINER_EN
  logic        trainer_flag;
`endif

  assign load_start = rom_loading & ~loading_q;
  assign load_end   = ~rom_loading & loading_q;
  assign byte_stb   = rom_do_valid & ~valid_q;
  assign prg_len    = 22'(prg_units) * 22'(PRG_UNIT);
  assign chr_len    = 22'(chr_units) * 22'(CHR_UNIT);
  assign loaded     = (state == S_DONE);
  assign error      = (state == S_ERR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      loading_q <= 1'b0;
      valid_q   <= 1'b0;
      state     <= S_IDLE;
      cnt       <= '0;
    end else begin
      loading_q <= rom_loading;
      valid_q   <= rom_do_valid;
      state     <= state_n;
      cnt       <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    hdr_we    = 1'b0;
    push      = 1'b0;
    push_data = '0;
    if (load_start) begin
      state_n = S_HEADER;
      cnt_n   = '0;
    end else if (load_end && (state inside {S_HEADER, S_TRAINER, S_PRG, S_CHR})) begin
      state_n = S_ERR;
    end else begin
      case (state)
        S_HEADER: if (byte_stb) begin
          hdr_we = 1'b1;
          cnt_n  = cnt + 22'd1;
          if (cnt < 22'd4 && rom_do != magic_byte(cnt[1:0])) begin
            state_n = S_ERR;
          end else if (cnt == 22'(HDR_LAST)) begin
            cnt_n = '0;
            if (prg_units == 8'd0)  state_n = S_ERR;
`ifdef NES_ROMLOAD_TRAINER_EN
            else if (trainer_flag)  state_n = S_TRAINER;
`endif
            else                    state_n = S_PRG;
          end
        end
`ifdef NES_ROMLOAD_TRAINER_EN
        S_TRAINER: if (byte_stb) begin
          if (cnt == 22'(TRAINER_LEN - 1)) begin
            cnt_n   = '0;
            state_n = S_PRG;
          end else begin
            cnt_n = cnt + 22'd1;
          end
        end
`endif
        S_PRG: if (byte_stb) begin
          if (full) begin
            state_n = S_ERR;
          end else begin
            push      = 1'b1;
            push_data = {PRG_BASE + {1'b0, cnt}, rom_do};
            if (cnt == prg_len - 22'd1) begin
              cnt_n   = '0;
              state_n = (chr_units == 8'd0) ? S_DRAIN : S_CHR;
            end else begin
              cnt_n = cnt + 22'd1;
            end
          end
        end
        S_CHR: if (byte_stb) begin
          if (full) begin
            state_n = S_ERR;
          end else begin
            push      = 1'b1;
            push_data = {CHR_BASE + {1'b0, cnt}, rom_do};
            if (cnt == chr_len - 22'd1) begin
              cnt_n   = '0;
              state_n = S_DRAIN;
            end else begin
              cnt_n = cnt + 22'd1;
            end
          end
        end
        S_DRAIN: if (empty) state_n = S_DONE;
        default: ;
      endcase
    end
  end

  // Header fields are captured one cycle after their byte is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prg_units <= '0;
      chr_units <= '0;
      mapper    <= '0;
      mirroring <= 1'b0;
      battery   <= 1'b0;
`ifdef NES_ROMLOAD_TRAINER_EN
      trainer_flag <= 1'b0;
`endif
    end else if (load_start) begin
      prg_units <= '0;
      chr_units <= '0;
      mapper    <= '0;
      mirroring <= 1'b0;
      battery   <= 1'b0;
`ifdef NES_ROMLOAD_TRAINER_EN
      trainer_flag <= 1'b0;
`endif
    end else if (hdr_we) begin
      case (cnt[3:0])
        4'(HDR_PRG): prg_units <= rom_do;
        4'(HDR_CHR): chr_units <= rom_do;
        4'(HDR_FLAGS6): begin
          mapper[3:0] <= rom_do[7:4];
          mirroring   <= rom_do[0];
          battery     <= rom_do[1];
`ifdef NES_ROMLOAD_TRAINER_EN
          trainer_flag <= rom_do[2];
`endif
        end
        4'(HDR_FLAGS7): mapper[7:4] <= rom_do[7:4];
        default: ;
      endcase
    end
  end

  romload_fifo #(
    .WIDTH(31),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (load_start),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Dropping the request after each ack guarantees an idle cycle between writes.
  assign pop = mem.mem_req & mem.mem_ack & ~load_start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem.mem_req   <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else if (load_start) begin
      mem.mem_req <= 1'b0;
    end else if (mem.mem_req) begin
      if (mem.mem_ack) mem.mem_req <= 1'b0;
    end else if (!empty) begin
      mem.mem_req   <= 1'b1;
      mem.mem_addr  <= head[30:8];
      mem.mem_wdata <= head[7:0];
    end
  end

endmodule

// File: doc/nes_romloader.md
# nes_romloader

Downstream consumer of the IO subsystem's ROM byte stream (`rom_loading`, `rom_do`, `rom_do_valid`).
- Parses the 16-byte iNES header and publishes cartridge configuration to the NES core.
- Writes PRG and CHR payload bytes into SDRAM through a byte-wide request/acknowledge port.
- Buffers in a small FIFO so SDRAM stalls never drop bytes.

## Interface
Parameters:
- `PRG_BASE`, 23'h000000, SDRAM byte address of PRG byte 0
- `CHR_BASE`, 23'h400000, SDRAM byte address of CHR byte 0
- `FIFO_DEPTH`, 16, write-buffer entries (power of two)

Ports:
- `clk` in 1, core clock, same domain as the IO subsystem
- `reset` in 1, asynchronous, active-high
- `rom_loading` in 1, high for the whole load
- `rom_do` in 8, stream byte
- `rom_do_valid` in 1, strobe; a byte is taken on its 0→1 edge only (the strobe is ≥2 cycles high)
- `mem_req` out 1, write request, level
- `mem_addr` out 23, write address
- `mem_wdata` out 8, write byte
- `mem_ack` in 1, one-cycle completion pulse
- `loaded` out 1, load complete and FIFO drained
- `error` out 1, sticky until next load start
- `prg_units` out 8, header byte 4 (16 KB units)
- `chr_units` out 8, header byte 5 (8 KB units)
- `mapper` out 8, {byte7[7:4], byte6[7:4]}
- `mirroring` out 1, byte6[0]
- `battery` out 1, byte6[1]

Clock/reset: one clock; reset is asynchronous and active-high.

## Operation
- States: IDLE, HEADER, TRAINER, PRG, CHR, DRAIN, DONE, ERR.
- Any rising edge of `rom_loading` (including mid-load) does all of the following, then enters HEADER:
  - flushes the FIFO and drops `mem_req`
  - clears the counters, `loaded`, `error` and all header outputs
- HEADER: byte counter 0..15.
  - Bytes 0–3 must be 4E 45 53 1A; a mismatch goes to ERR.
  - Bytes 4–7 latch the header outputs.
  - Bytes 8–15 are ignored.
  - After byte 15: `prg_units==0` goes to ERR; byte6[2] set goes to TRAINER (see Configuration); otherwise PRG.
- TRAINER: discards 512 bytes, then goes to PRG.
- PRG: section length = `prg_units`×16384.
  - Each accepted byte pushes {PRG_BASE+offset, byte} into the FIFO.
  - At the last byte, goes to CHR, or to DRAIN if `chr_units==0`.
- CHR: same as PRG with length `chr_units`×8192 and base `CHR_BASE`; after the last byte, goes to DRAIN.
- DRAIN: waits for the FIFO to empty, then DONE (`loaded`=1). Bytes arriving in DRAIN or DONE are ignored.
- Falling edge of `rom_loading` in HEADER, TRAINER, PRG or CHR goes to ERR (short file).
- A byte arriving while the FIFO is full is dropped and the block goes to ERR.
- In ERR:
  - `error`=1
  - the FIFO keeps draining
  - `loaded` stays 0
  - input bytes are ignored
- Offset counter is 22 bits and never wraps (max 255×16384−1 fits).

## Timing
- Reset values: every output is 0, `mem_addr`=0, `mem_wdata`=0; state is IDLE.
- Byte acceptance:
  - Edge detected on the cycle `rom_do_valid`=1 and the registered previous value =0.
  - FIFO write occurs on the same cycle.
  - Header outputs update the following cycle.
- Memory handshake:
  - `mem_req` rises the cycle after the FIFO becomes non-empty.
  - `mem_addr` and `mem_wdata` are held stable while `mem_req`=1.
  - On `mem_ack` the FIFO pops, and `mem_req` is low for at least one cycle before the next request.
- `mem_ack` while `mem_req`=0 is ignored.
- A simultaneous push and pop in the same cycle is legal; the count is unchanged.
- `loaded` rises the cycle after the FIFO becomes empty in DRAIN.

## Configuration
- Macro: `NES_ROMLOAD_TRAINER_EN`.
- Defined: byte6[2] selects TRAINER and 512 bytes are skipped.
- Undefined: byte6[2] is ignored, the TRAINER state is not built, and the data following the header is taken as PRG.

## Structure
- Package `nes_romload_pkg` holds:
  - state enum
  - iNES magic constant
  - header byte indices
  - unit sizes (16384, 8192)
  - trainer length 512
- Sub-module `romload_fifo`: synchronous FIFO.
  - Width 31 (23 address + 8 data), depth `FIFO_DEPTH`.
  - Ports: push, pop, full, empty, and the data ports.

## Test plan
- Valid header (prg 1, chr 1, mapper 4, mirroring 1) then 24576 bytes, `mem_ack` 2 cycles after each req:
  - 16384 writes at 0x000000.., then 8192 writes at 0x400000..
  - `loaded`=1, `mapper`=8'h04.
- Header byte 0 = 4F: `error`=1 and no `mem_req` ever.
- `mem_ack` withheld for 200 cycles during PRG at one byte per 4 cycles: FIFO overflows and `error`=1. Repeat with a 40-cycle withhold: no error and no lost bytes.
- `rom_loading` falls after 1000 PRG bytes: `error`=1 and exactly 1000 writes complete.
- `rom_loading` re-asserted mid-CHR: outputs clear within 1 cycle and a second full load yields `loaded`=1.
- With `NES_ROMLOAD_TRAINER_EN` and byte6=8'h04: the first PRG write carries stream byte 528 at address 0x000000.
